um_tx_sched: RTL

- Parametrised successor to the single-source transmit stage: schedules whole packets from NUM_CH upstream channels (control path, action output, future sources) onto the single CDP transmit interface.
- Sits between the per-channel packet/rule FIFOs and the CDP.
- Per-packet rule write to the CDP rule FIFO, then the packet's data words.
- Supports round-robin or channel-0 strict priority, rule-FIFO backpressure, and max-length truncation with flush.

---
 rtl/um_tx_sched_if.sv | 34 +++
 rtl/um_tx_sched.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/um_tx_sched_if.sv
// Bundle of the per-channel source FIFO signals and the CDP transmit signals.
// The scheduler sits on the master side; sources and the CDP sit on the slave side.
interface um_tx_sched_if #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 139,
    parameter int RULE_W = 30
);
    logic [NUM_CH-1:0]        ch_rule_valid;
    logic [NUM_CH*RULE_W-1:0] ch_rule;
    logic [NUM_CH-1:0]        ch_rule_rd;
    logic [NUM_CH-1:0]        ch_pkt_valid;
    logic [NUM_CH*DATA_W-1:0] ch_pkt;
    logic [NUM_CH-1:0]        ch_pkt_rd;
    logic                     cdp2um_tx_enable;
    logic [4:0]               cdp2um_rule_usedw;
    logic                     um2cdp_rule_wrreq;
    logic [RULE_W-1:0]        um2cdp_rule;
    logic                     um2cdp_data_valid;
    logic [DATA_W-1:0]        um2cdp_data;

    modport master (
        input  ch_rule_valid, ch_rule, ch_pkt_valid, ch_pkt,
        input  cdp2um_tx_enable, cdp2um_rule_usedw,
        output ch_rule_rd, ch_pkt_rd,
        output um2cdp_rule_wrreq, um2cdp_rule, um2cdp_data_valid, um2cdp_data
    );

    modport slave (
        output ch_rule_valid, ch_rule, ch_pkt_valid, ch_pkt,
        output cdp2um_tx_enable, cdp2um_rule_usedw,
        input  ch_rule_rd, ch_pkt_rd,
        input  um2cdp_rule_wrreq, um2cdp_rule, um2cdp_data_valid, um2cdp_data
    );
endinterface

// File: rtl/um_tx_sched.sv
// Whole-packet transmit scheduler: arbitrates NUM_CH source channels onto the CDP,
// writing one rule per packet followed by its data words, with truncation and flush.
module um_tx_sched #(
    parameter int NUM_CH     = 2,
    parameter int DATA_W     = 139,
    parameter int RULE_W     = 30,
    parameter int PRIO_CH0   = 0,
    parameter int RULE_AFULL = 28,
    parameter int MAX_WORDS  = 128
) (
    input  logic          clk,
    input  logic          reset,
    um_tx_sched_if.master bus,
    output logic [31:0]   tx_pkt_cnt,
    output logic [15:0]   trunc_cnt
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WC_W = $clog2(MAX_WORDS + 1);
    localparam logic [2:0] TYPE_TAIL = 3'b110;

    typedef enum logic [2:0] {IDLE, RULE, DATA, FLUSH, GAP} state_t;

    state_t              state;
    logic [CH_W-1:0]     gnt_ch;
    logic [CH_W-1:0]     rr_last;
    logic [WC_W-1:0]     wc;
    logic                rule_wrreq_q;
    logic [RULE_W-1:0]   rule_q;
    logic                data_valid_q;
    logic [DATA_W-1:0]   data_q;

    logic                arb_valid;
    logic [CH_W-1:0]     arb_ch;
    logic                grant_ok;
    logic [RULE_W-1:0]   sel_rule;
    logic [DATA_W-1:0]   sel_word;
    logic                sel_valid;
    logic                sel_tail;
    logic [NUM_CH-1:0]   rule_rd;
    logic [NUM_CH-1:0]   pkt_rd;

    function automatic logic [CH_W-1:0] wrap_ch(input int v);
        return CH_W'(v % NUM_CH);
    endfunction

    // Round-robin search starts just after the last grant; with PRIO_CH0 set,
    // channel 0 pre-empts the search and is skipped inside it.
    always_comb begin
        arb_valid = 1'b0;
        arb_ch    = '0;
        if (PRIO_CH0 != 0 && bus.ch_rule_valid[0]) begin
            arb_valid = 1'b1;
        end else begin
            for (int k = 1; k <= NUM_CH; k++) begin
                if (!arb_valid && bus.ch_rule_valid[wrap_ch(int'(rr_last) + k)] &&
                    !(PRIO_CH0 != 0 && wrap_ch(int'(rr_last) + k) == '0)) begin
                    arb_valid = 1'b1;
                    arb_ch    = wrap_ch(int'(rr_last) + k);
                end
            end
        end
    end

    assign grant_ok = bus.cdp2um_tx_enable && (int'(bus.cdp2um_rule_usedw) < RULE_AFULL);

    always_comb begin
        sel_rule  = '0;
        sel_word  = '0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (gnt_ch == CH_W'(i)) begin
                sel_rule  = bus.ch_rule[i*RULE_W +: RULE_W];
                sel_word  = bus.ch_pkt[i*DATA_W +: DATA_W];
                sel_valid = bus.ch_pkt_valid[i];
            end
        end
    end

    assign sel_tail = (sel_word[DATA_W-1 -: 3] == TYPE_TAIL);

    always_comb begin
        rule_rd = '0;
        pkt_rd  = '0;
        if (state == RULE) begin
            rule_rd[gnt_ch] = 1'b1;
        end
        if (state == DATA || state == FLUSH) begin
            pkt_rd[gnt_ch] = sel_valid;
        end
    end

    assign bus.ch_rule_rd        = rule_rd;
    assign bus.ch_pkt_rd         = pkt_rd;
    assign bus.um2cdp_rule_wrreq = rule_wrreq_q;
    assign bus.um2cdp_rule       = rule_q;
    assign bus.um2cdp_data_valid = data_valid_q;
    assign bus.um2cdp_data       = data_q;

    // Transmit state machine; strobes default low so every write is a one-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            gnt_ch       <= '0;
            rr_last      <= CH_W'(NUM_CH - 1);
            wc           <= '0;
            rule_wrreq_q <= 1'b0;
            rule_q       <= '0;
            data_valid_q <= 1'b0;
            data_q       <= '0;
            tx_pkt_cnt   <= '0;
            trunc_cnt    <= '0;
        end else begin
            rule_wrreq_q <= 1'b0;
            data_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_valid && grant_ok) begin
                        gnt_ch  <= arb_ch;
                        rr_last <= arb_ch;
                        state   <= RULE;
                    end
                end
                RULE: begin
                    rule_wrreq_q <= 1'b1;
                    rule_q       <= sel_rule;
                    wc           <= '0;
                    state        <= DATA;
                end
                DATA: begin
                    if (sel_valid) begin
                        data_valid_q <= 1'b1;
                        wc           <= wc + 1'b1;
                        if (sel_tail) begin
                            data_q     <= sel_word;
                            tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
                            state      <= GAP;
                        end else if (wc == WC_W'(MAX_WORDS - 1)) begin
                            // Over-long packet: close it with a forced tail, drop the rest.
                            data_q     <= {TYPE_TAIL, sel_word[DATA_W-4:0]};
                            tx_pkt_cnt <= tx_pkt_cnt + 32'd1;
                            if (trunc_cnt != 16'hFFFF) begin
                                trunc_cnt <= trunc_cnt + 16'd1;
                            end
                            state      <= FLUSH;
                        end else begin
                            data_q <= sel_word;
                        end
                    end
                end
                FLUSH: begin
                    if (sel_valid && sel_tail) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
